// File: rtl/axi_m_arbiter.sv
// Shares one AXI master between the I-cache and D-cache: one line transaction in flight,
// registered outputs, round-robin or DC-priority arbitration.
module axi_m_arbiter #(
   parameter int PRIO_MODE  = 0,
   parameter int LINE_BYTES = 16
) (
   input  logic         M_AXI_ACLK,
   input  logic         M_AXI_ARESETN,
   input  logic         ic_req_i,
   input  logic [31:0]  ic_addr_i,
   output logic [127:0] ic_rdata_o,
   output logic         ic_done_o,
   input  logic         dc_req_i,
   input  logic         dc_rw_i,
   input  logic [31:0]  dc_addr_i,
   input  logic [127:0] dc_wdata_i,
   output logic [127:0] dc_rdata_o,
   output logic         dc_done_o,
   output logic         arb_valid_req_o,
   output logic         arb_rw_o,
   output logic [31:0]  arb_addr_o,
   output logic [127:0] arb_data_o,
   input  logic [127:0] axi_data_i,
   input  logic         axi_rd_over_i,
   input  logic         axi_wr_over_i,
   output logic         busy_o,
   output logic         owner_o
);

   localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic          valid_reg, valid_next;
   logic          rw_reg, rw_next;
   logic [31:0]   addr_reg, addr_next;
   logic [127:0]  data_reg, data_next;
   logic          ic_done_reg, ic_done_next;
   logic          dc_done_reg, dc_done_next;
   logic          busy_reg, busy_next;
   logic          owner_reg, owner_next;
   logic          favour_dc_reg, favour_dc_next;
   logic          grant_dc;
   logic [1:0]    rd_capture;
   logic [1:0][127:0] rdata_all;

   // With round-robin, DC wins a tie only when IC was served last.
   always_comb begin
      if (PRIO_MODE == 1)
         grant_dc = dc_req_i;
      else
         grant_dc = dc_req_i & (~ic_req_i | favour_dc_reg);
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_reg     <= ST_IDLE;
         valid_reg     <= 1'b0;
         rw_reg        <= 1'b0;
         addr_reg      <= '0;
         data_reg      <= '0;
         ic_done_reg   <= 1'b0;
         dc_done_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         owner_reg     <= 1'b0;
         favour_dc_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         valid_reg     <= valid_next;
         rw_reg        <= rw_next;
         addr_reg      <= addr_next;
         data_reg      <= data_next;
         ic_done_reg   <= ic_done_next;
         dc_done_reg   <= dc_done_next;
         busy_reg      <= busy_next;
         owner_reg     <= owner_next;
         favour_dc_reg <= favour_dc_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      valid_next     = 1'b0;
      rw_next        = rw_reg;
      addr_next      = addr_reg;
      data_next      = data_reg;
      ic_done_next   = 1'b0;
      dc_done_next   = 1'b0;
      owner_next     = owner_reg;
      favour_dc_next = favour_dc_reg;
      rd_capture     = 2'b00;

      case (state_reg)
         ST_IDLE: begin
            if (ic_req_i || dc_req_i) begin
               owner_next = grant_dc;
               rw_next    = grant_dc ? dc_rw_i : 1'b1;
               addr_next  = (grant_dc ? dc_addr_i : ic_addr_i) & LINE_MASK;
               data_next  = grant_dc ? dc_wdata_i : '0;
               valid_next = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // Only the over pulse matching the latched direction completes the transaction.
            if ((rw_reg && axi_rd_over_i) || (!rw_reg && axi_wr_over_i)) begin
               state_next   = ST_DONE;
               ic_done_next = ~owner_reg;
               dc_done_next = owner_reg;
               if (rw_reg)
                  rd_capture[owner_reg] = 1'b1;
            end
         end
         ST_DONE: begin
            favour_dc_next = ~owner_reg;
            state_next     = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      busy_next = (state_next != ST_IDLE);
   end

   // One line register per requester; index 0 is IC, 1 is DC.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rdata
         logic [127:0] rdata_reg;
         always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
            if (!M_AXI_ARESETN)
               rdata_reg <= '0;
            else if (rd_capture[gi])
               rdata_reg <= axi_data_i;
         end
         assign rdata_all[gi] = rdata_reg;
      end
   endgenerate

   assign arb_valid_req_o = valid_reg;
   assign arb_rw_o        = rw_reg;
   assign arb_addr_o      = addr_reg;
   assign arb_data_o      = data_reg;
   assign ic_done_o       = ic_done_reg;
   assign dc_done_o       = dc_done_reg;
   assign ic_rdata_o      = rdata_all[0];
   assign dc_rdata_o      = rdata_all[1];
   assign busy_o          = busy_reg;
   assign owner_o         = owner_reg;

endmodule

// File: tb/tb_axi_m_arbiter.sv
// Bench for axi_m_arbiter: directed table, corner sequences, random traffic vs. a
// transaction-level model, and a fixed-priority instance.
module tb_axi_m_arbiter;

   localparam int LB = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ic_req = 1'b0, dc_req = 1'b0, dc_rw = 1'b0;
   logic [31:0]  ic_addr = '0, dc_addr = '0;
   logic [127:0] dc_wdata = '0, axi_data = '0;
   logic         rd_over = 1'b0, wr_over = 1'b0;
   logic         valid, rw, ic_done, dc_done, busy, owner;
   logic [31:0]  addr;
   logic [127:0] data, ic_rdata, dc_rdata;
   logic         fp_ic_req = 1'b0, fp_dc_req = 1'b0;
   logic         fp_valid, fp_rw, fp_ic_done, fp_dc_done, fp_busy, fp_owner;
   logic [31:0]  fp_addr;
   logic [127:0] fp_data, fp_ic_rdata, fp_dc_rdata;

   int checks = 0, failures = 0;
   int strobes_seen = 0, dones_seen = 0, exp_strobes = 0;
   logic [127:0] m_rdata [2];
   logic         m_last;

   always #5 clk = ~clk;

   axi_m_arbiter #(.PRIO_MODE(0), .LINE_BYTES(LB)) u_rr (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_rdata_o(ic_rdata), .ic_done_o(ic_done),
      .dc_req_i(dc_req), .dc_rw_i(dc_rw), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
      .dc_rdata_o(dc_rdata), .dc_done_o(dc_done),
      .arb_valid_req_o(valid), .arb_rw_o(rw), .arb_addr_o(addr), .arb_data_o(data),
      .axi_data_i(axi_data), .axi_rd_over_i(rd_over), .axi_wr_over_i(wr_over),
      .busy_o(busy), .owner_o(owner)
   );

   axi_m_arbiter #(.PRIO_MODE(1), .LINE_BYTES(LB)) u_fp (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .ic_req_i(fp_ic_req), .ic_addr_i(ic_addr), .ic_rdata_o(fp_ic_rdata), .ic_done_o(fp_ic_done),
      .dc_req_i(fp_dc_req), .dc_rw_i(dc_rw), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
      .dc_rdata_o(fp_dc_rdata), .dc_done_o(fp_dc_done),
      .arb_valid_req_o(fp_valid), .arb_rw_o(fp_rw), .arb_addr_o(fp_addr), .arb_data_o(fp_data),
      .axi_data_i(axi_data), .axi_rd_over_i(rd_over), .axi_wr_over_i(wr_over),
      .busy_o(fp_busy), .owner_o(fp_owner)
   );

   always @(negedge clk) begin
      if (valid === 1'b1) strobes_seen++;
      if (ic_done === 1'b1 || dc_done === 1'b1) dones_seen++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transaction on the round-robin instance, checked against the expectation.
   task automatic run_txn(input logic e_owner, input logic e_rw, input logic [31:0] e_addr,
                          input logic [127:0] e_data, input logic [127:0] resp,
                          input bit spurious, input bit hold);
      int n = 0;
      while (valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      exp_strobes++;
      chk("strobe_seen", valid, 1'b1);
      if (valid !== 1'b1) return;
      chk("owner", owner, e_owner);
      chk("rw", rw, e_rw);
      chk("addr", addr, e_addr);
      chk("wdata", data, e_data);
      chk("busy_issue", busy, 1'b1);
      // Requester changes its inputs after the latch; the transaction must not notice.
      if (e_owner) begin
         dc_addr = $urandom; dc_wdata = {$urandom, $urandom, $urandom, $urandom}; dc_rw = ~dc_rw;
      end else begin
         ic_addr = $urandom;
      end
      @(posedge clk); #1;
      chk("strobe_one_cycle", valid, 1'b0);
      if (spurious) begin
         axi_data = ~resp;
         if (e_rw) wr_over = 1'b1; else rd_over = 1'b1;
         @(posedge clk); #1;
         rd_over = 1'b0; wr_over = 1'b0;
         chk("spurious_ignored", {ic_done, dc_done, busy}, 3'b001);
      end
      axi_data = resp;
      if (e_rw) rd_over = 1'b1; else wr_over = 1'b1;
      @(posedge clk); #1;
      rd_over = 1'b0; wr_over = 1'b0;
      axi_data = {$urandom, $urandom, $urandom, $urandom};
      if (e_rw) m_rdata[e_owner] = resp;
      m_last = e_owner;
      chk("done_owner", {ic_done, dc_done}, e_owner ? 2'b01 : 2'b10);
      chk("ic_rdata", ic_rdata, m_rdata[0]);
      chk("dc_rdata", dc_rdata, m_rdata[1]);
      @(posedge clk); #1;
      if (!hold) begin
         if (e_owner) dc_req = 1'b0; else ic_req = 1'b0;
      end
      chk("done_single", {ic_done, dc_done}, 2'b00);
      chk("idle_gap", {busy, valid}, 2'b00);
      $display("txn owner=%0d rw=%0d addr=%h", e_owner, e_rw, e_addr);
   endtask

   typedef struct {
      logic         ic_req;
      logic [31:0]  ic_addr;
      logic         dc_req;
      logic         dc_rw;
      logic [31:0]  dc_addr;
      logic [127:0] dc_wdata;
      logic [127:0] resp;
      bit           spurious;
      logic         exp_owner;
      logic         exp_rw;
      logic [31:0]  exp_addr;
      logic [127:0] exp_data;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic         w, e_rw;
      logic [31:0]  a;
      logic [127:0] e_data;
      int           d0, n;

      vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 128'h0,
                  128'h0123456789ABCDEF_0123456789ABCDEF, 1'b0,
                  1'b0, 1'b1, 32'h0000_1230, 128'h0};
      vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0010, 128'hAAAAAAAA_AAAAAAAA_55555555_55555555,
                  128'h0F0F, 1'b1,
                  1'b1, 1'b0, 32'h8000_0010, 128'hAAAAAAAA_AAAAAAAA_55555555_55555555};
      vecs[2] = '{1'b1, 32'h0000_100F, 1'b1, 1'b1, 32'h0000_2005, 128'h1111,
                  128'h3333, 1'b0,
                  1'b0, 1'b1, 32'h0000_1000, 128'h0};
      vecs[3] = '{1'b1, 32'h0000_300C, 1'b1, 1'b1, 32'h0000_2005, 128'h1111,
                  128'h4444, 1'b1,
                  1'b1, 1'b1, 32'h0000_2000, 128'h1111};
      vecs[4] = '{1'b1, 32'h0000_300C, 1'b1, 1'b0, 32'h4444_4448, 128'hDEADBEEF_00000000_CAFEF00D_12345678,
                  128'h5555, 1'b0,
                  1'b0, 1'b1, 32'h0000_3000, 128'h0};
      vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h4444_4448, 128'hDEADBEEF_00000000_CAFEF00D_12345678,
                  128'h6666, 1'b1,
                  1'b1, 1'b0, 32'h4444_4440, 128'hDEADBEEF_00000000_CAFEF00D_12345678};
      vecs[6] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 128'h0,
                  128'h7777, 1'b0,
                  1'b0, 1'b1, 32'hFFFF_FFF0, 128'h0};

      m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1'b1;

      // Reset values
      repeat (3) @(posedge clk); #1;
      chk("reset_flags", {valid, rw, ic_done, dc_done, busy, owner}, 6'b0);
      chk("reset_addr", addr, 32'h0);
      chk("reset_data", data, 128'h0);
      chk("reset_rdata", ic_rdata | dc_rdata, 128'h0);
      rst_n = 1'b1;

      // Over pulses while idle do nothing
      @(posedge clk); #1;
      rd_over = 1'b1; wr_over = 1'b1; axi_data = '1;
      @(posedge clk); #1;
      rd_over = 1'b0; wr_over = 1'b0;
      @(posedge clk); #1;
      chk("idle_over_ignored", {busy, ic_done, dc_done}, 3'b000);
      chk("idle_over_rdata", ic_rdata | dc_rdata, 128'h0);

      // Reset while waiting for the write-over
      dc_req = 1'b1; dc_rw = 1'b0; dc_addr = 32'h0000_0040; dc_wdata = 128'hBEEF;
      n = 0;
      while (valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      exp_strobes++;
      chk("rst_strobe_seen", valid, 1'b1);
      @(posedge clk); #1;
      chk("rst_in_wait", busy, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_flags", {valid, rw, ic_done, dc_done, busy, owner}, 6'b0);
      chk("async_addr_data", {addr, data[95:0]}, 128'h0);
      dc_req = 1'b0;
      d0 = dones_seen;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("no_done_after_rst", 32'(dones_seen), 32'(d0));
      chk("idle_after_rst", busy, 1'b0);
      $display("reset during wait applied");

      // Directed table
      for (int i = 0; i < 7; i++) begin
         ic_req = vecs[i].ic_req; ic_addr = vecs[i].ic_addr;
         dc_req = vecs[i].dc_req; dc_rw = vecs[i].dc_rw;
         dc_addr = vecs[i].dc_addr; dc_wdata = vecs[i].dc_wdata;
         run_txn(vecs[i].exp_owner, vecs[i].exp_rw, vecs[i].exp_addr, vecs[i].exp_data,
                 vecs[i].resp, vecs[i].spurious, 1'b0);
      end

      // Requester holds req past done: a second transaction follows
      ic_req = 1'b1; ic_addr = 32'h0000_0A0A;
      run_txn(1'b0, 1'b1, 32'h0000_0A00, 128'h0, 128'hA1A1, 1'b0, 1'b1);
      $display("note: requester protocol violation, ic_req held past ic_done");
      a = ic_addr;
      run_txn(1'b0, 1'b1, a - (a % LB), 128'h0, 128'hA2A2, 1'b0, 1'b0);

      // Random traffic against the transaction-level model
      for (int it = 0; it < 40; it++) begin
         if (!ic_req && $urandom_range(0, 1) == 1) begin
            ic_req = 1'b1; ic_addr = $urandom;
         end
         if (!dc_req && $urandom_range(0, 1) == 1) begin
            dc_req = 1'b1; dc_rw = 1'($urandom); dc_addr = $urandom;
            dc_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         if (!ic_req && !dc_req) begin
            ic_req = 1'b1; ic_addr = $urandom;
         end
         w      = (ic_req && dc_req) ? ~m_last : dc_req;
         e_rw   = w ? dc_rw : 1'b1;
         a      = w ? dc_addr : ic_addr;
         e_data = w ? dc_wdata : 128'h0;
         run_txn(w, e_rw, a - (a % LB), e_data, {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'b0);
      end
      ic_req = 1'b0; dc_req = 1'b0;

      // Fixed priority: DC wins while it keeps requesting
      fp_ic_req = 1'b1; fp_dc_req = 1'b1; dc_rw = 1'b1;
      ic_addr = 32'h0000_0104; dc_addr = 32'h0000_0208;
      for (int t = 0; t < 4; t++) begin
         n = 0;
         while (fp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
         end
         chk("fp_strobe_seen", fp_valid, 1'b1);
         chk("fp_owner", fp_owner, (t < 3) ? 1'b1 : 1'b0);
         chk("fp_addr", fp_addr, (t < 3) ? 32'h0000_0200 : 32'h0000_0100);
         @(posedge clk); #1;
         axi_data = 128'(32'hF00 + t);
         rd_over = 1'b1;
         @(posedge clk); #1;
         rd_over = 1'b0;
         chk("fp_done", {fp_ic_done, fp_dc_done}, (t < 3) ? 2'b01 : 2'b10);
         if (t == 3) chk("fp_ic_rdata", fp_ic_rdata, 128'h0F03);
         $display("fp grant %0d owner=%0d", t, fp_owner);
         @(posedge clk); #1;
         if (t == 2) fp_dc_req = 1'b0;
         if (t == 3) fp_ic_req = 1'b0;
      end

      repeat (4) @(posedge clk); #1;
      chk("strobe_count", 32'(strobes_seen), 32'(exp_strobes));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
